// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register load controller:
// FSM state encoding, default register width and counter sizing helper.
package shift_ctrl_pkg;

    // Default number of bits in the target shift register.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Load controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit counter width: one bit more than needed to index the word,
    // so the counter can reach WIDTH without wrapping.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_load_ctrl_if.sv
// Handshake and shift-register control bundle for shift_load_ctrl.
// Optional feature macro: READBACK_CHECK_EN adds sr_q readback and match.
import shift_ctrl_pkg::*;

interface shift_load_ctrl_if #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    // Requester side
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] data_in;

    // Status back to requester
    logic             ready;
    logic             busy;
    logic             done;

    // Shift register control
    logic             sr_clear_n;
    logic             sr_shift;
    logic             sr_in;

`ifdef READBACK_CHECK_EN
    logic [WIDTH-1:0] sr_q;
    logic             match;

    // Requester / environment side
    modport master (
        output start, abort, data_in, sr_q,
        input  ready, busy, done, sr_clear_n, sr_shift, sr_in, match
    );

    // Controller side
    modport slave (
        input  start, abort, data_in, sr_q,
        output ready, busy, done, sr_clear_n, sr_shift, sr_in, match
    );
`else
    // Requester / environment side
    modport master (
        output start, abort, data_in,
        input  ready, busy, done, sr_clear_n, sr_shift, sr_in
    );

    // Controller side
    modport slave (
        input  start, abort, data_in,
        output ready, busy, done, sr_clear_n, sr_shift, sr_in
    );
`endif

endinterface

// File: rtl/shift_bit_counter.sv
// Bit counter for the shift phase: synchronous clear, count enable,
// saturates at WIDTH so it never wraps inside one load. The terminal flag
// marks the last bit position (WIDTH-1).
import shift_ctrl_pkg::*;

module shift_bit_counter #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          enable,
    output logic [cnt_width(WIDTH)-1:0]   count,
    output logic                          terminal
);

    localparam int unsigned CW = cnt_width(WIDTH);

    // Count register: clear has priority, increment holds at WIDTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(WIDTH))) begin
            count <= count + CW'(1);
        end
    end

    // Terminal flag: current count addresses the final bit.
    always_comb begin
        terminal = (count == CW'(WIDTH - 1));
    end

endmodule

// File: rtl/shift_load_ctrl.sv
// Serial loader for an external shift register. Captures a parallel word on
// start, clears the target register for one cycle, then shifts the word out
// LSB first so the register (shifting in at its MSB) ends up holding it.
// Optional feature macro: READBACK_CHECK_EN compares sr_q against the
// captured word while done is high and reports the result on match.
import shift_ctrl_pkg::*;

module shift_load_ctrl #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    shift_load_ctrl_if.slave     bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count;
    logic             terminal;
    logic             capture;
    logic             cnt_clear;
    logic             cnt_en;

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .count    (count),
        .terminal (terminal)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shadow word: captured once on start acceptance, held for the load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (capture) begin
            shadow <= bus.data_in;
        end
    end

    // Next-state and counter control; abort beats start and cancels a load.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    capture    = 1'b1;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_clear  = 1'b1;
                state_next = bus.abort ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_en = 1'b1;
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (terminal) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; sr_clear_n also follows reset directly so
    // the target register is held clear for the whole reset period.
    always_comb begin
        shifted        = shadow >> count;
        bus.ready      = (state == ST_IDLE);
        bus.busy       = (state == ST_CLEAR) || (state == ST_SHIFT);
        bus.done       = (state == ST_DONE);
        bus.sr_shift   = (state == ST_SHIFT);
        bus.sr_in      = (state == ST_SHIFT) ? shifted[0] : 1'b0;
        bus.sr_clear_n = reset && (state != ST_CLEAR);
    end

`ifdef READBACK_CHECK_EN
    // Readback compare, presented alongside done.
    always_comb begin
        bus.match = (state == ST_DONE) && (bus.sr_q == shadow);
    end
`endif

endmodule

// File: doc/shift_load_ctrl.md
SHIFT_LOAD_CTRL -- requirements
Module: shift_load_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of bits in the target shift register.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  load request, sampled on rising edge.
REQ-005 abort  input  1  synchronous cancel of a load in progress.
REQ-006 data_in  input  WIDTH  parallel word to load, captured on start acceptance.
REQ-007 ready  output  1  high when idle and able to accept start.
REQ-008 busy  output  1  high in CLEAR and SHIFT.
REQ-009 done  output  1  one-cycle pulse on load completion.
REQ-010 sr_clear_n  output  1  active-low clear to shift register.
REQ-011 sr_shift  output  1  shift enable to shift register.
REQ-012 sr_in  output  1  serial data bit to shift register.
REQ-013 sr_q  input  WIDTH  parallel readback from shift register (READBACK_CHECK_EN only).
REQ-014 match  output  1  readback equals captured word, valid with done (READBACK_CHECK_EN only).

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, SHIFT, DONE.
REQ-016 IDLE: ready=1; start=1 and abort=0 -> capture data_in into shadow, go CLEAR.
REQ-017 CLEAR: sr_clear_n=0 for exactly one cycle, bit counter := 0, then SHIFT.
REQ-018 SHIFT: sr_shift=1, sr_in=shadow[counter], counter++ each cycle; after WIDTH cycles go DONE.
REQ-019 Target register shifts in at MSB toward bit 0; data_in[0] is sent first, so after WIDTH shifts sr_q equals the captured word.
REQ-020 DONE: done=1 for one cycle, sr_shift=0, then IDLE.
REQ-021 Latency: done asserts exactly WIDTH+2 cycles after the start-accept edge; ready returns the following cycle.
REQ-022 start while not in IDLE SHALL be ignored; data_in changes after capture SHALL have no effect.
REQ-023 abort in CLEAR or SHIFT -> IDLE next cycle, no done pulse, sr_shift=0 immediately in that next cycle.
REQ-024 abort and start together in IDLE: abort wins, no capture.
REQ-025 Outside SHIFT, sr_shift=0 and sr_in=0; outside CLEAR, sr_clear_n=1.
REQ-026 Counter width SHALL be $clog2(WIDTH)+1 bits and SHALL NOT wrap within one load.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, shadow=0, counter=0, ready=1, busy=0, done=0, sr_shift=0, sr_in=0, sr_clear_n=0, match=0.
REQ-028 sr_clear_n SHALL follow reset asynchronously, clearing the target register during reset.
REQ-029 Reset asserted mid-load SHALL discard the load with no done pulse.

Configuration
REQ-030 Macro READBACK_CHECK_EN defined: sr_q and match ports exist; in DONE, match := (sr_q == shadow).
REQ-031 READBACK_CHECK_EN undefined: sr_q and match ports absent; all other behaviour identical.

Structure
REQ-032 Shared package shift_ctrl_pkg SHALL hold the state enum typedef and the default WIDTH constant.
REQ-033 Bit counter SHALL be a sub-module shift_bit_counter (clear, enable, count, terminal flag).

Verification
REQ-034 Reset low 20 ns then high -> ready=1, busy=0, sr_clear_n low during reset, all other outputs 0.
REQ-035 start with data_in=4'b1011 -> sr_clear_n low 1 cycle, sr_in sequence 1,1,0,1 over 4 sr_shift cycles, done at cycle 6, match=1.
REQ-036 Readback with sr_q forced to 4'b0011 while loading 4'b1011 -> match=0 on done.
REQ-037 abort after 2nd shift cycle -> IDLE next cycle, no done, ready=1; a new start with 4'b0110 then completes normally.
REQ-038 start pulsed again during SHIFT with data_in=4'b1111 -> ignored; serial stream still reflects first captured word.
REQ-039 reset asserted during SHIFT -> outputs to reset values at once, no done after release.
